// File: rtl/mc_control_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_control_fsm_if
// Bundles every signal between the multicycle control sequencer and the
// datapath/memory side of the RV32I core. Clock and reset stay outside.
//
// Memory handshake: the sequencer holds mem_read high for as long as it wants
// read data (instruction fetch or load). The access completes on the first
// rising edge where mem_read and mem_ready are both high. mem_ready is
// ignored in every other cycle. A store is a single-cycle mem_write strobe
// and is not acknowledged.
//
// master : the sequencer (takes IR fields and memory status, drives selects)
// slave  : datapath / memory side (the reverse)
// CNT_W must match the CNT_W of the sequencer it is connected to.
// ---------------------------------------------------------------------------
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;       // IR[6:0]
    logic [2:0]       funct3;       // IR[14:12]
    logic             mem_ready;    // read data valid / access complete
    logic             stall_req;    // debug stall, only looked at in FETCH
    logic             fetch_cycle;  // memory address = PC
    logic             ir_write;     // load IR from read data
    logic             pc_write;     // PC update
    logic             reg_write;    // register-file write enable
    logic             mem_read;     // memory read request
    logic             mem_write;    // memory write strobe
    logic             is_branch;    // branch in EXEC
    logic             is_jal;       // JAL in EXEC
    logic             is_jalr;      // JALR in EXEC
    logic [1:0]       alu_src_a;    // 00 rs1, 01 PC, 10 zero
    logic [1:0]       alu_src_b;    // 00 rs2, 01 imm, 10 const 4
    logic [1:0]       wb_sel;       // 00 ALU reg, 01 mem data reg, 10 PC+4
    logic [3:0]       state;        // debug view of the sequencer state
    logic             trap;         // high while trapped
    logic [1:0]       trap_cause;   // 01 illegal opcode, 10 bus timeout
    logic             halted;       // high in TRAP or HALT
    logic [CNT_W-1:0] instret;      // retired-instruction count

    modport master (
        input  opcode, funct3, mem_ready, stall_req,
        output fetch_cycle, ir_write, pc_write, reg_write, mem_read, mem_write,
               is_branch, is_jal, is_jalr, alu_src_a, alu_src_b, wb_sel,
               state, trap, trap_cause, halted, instret
    );

    modport slave (
        output opcode, funct3, mem_ready, stall_req,
        input  fetch_cycle, ir_write, pc_write, reg_write, mem_read, mem_write,
               is_branch, is_jal, is_jalr, alu_src_a, alu_src_b, wb_sel,
               state, trap, trap_cause, halted, instret
    );
endinterface

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Multicycle control sequencer for the RV32I core:
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
// Adds a variable-latency memory handshake with bus timeout, an illegal-opcode
// trap, ECALL/EBREAK halt, a debug stall in FETCH and a retired-instruction
// counter.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mc_control_fsm_if.master (IR fields, memory status in;
//            strobes, mux selects, state/trap/halt status, instret out)
//
// Parameters
//   MEM_TIMEOUT : wait cycles on mem_ready before a bus-timeout trap, 0 = off
//   HALT_ON_SYS : 1 -> SYSTEM funct3=0 halts, 0 -> executes as a NOP
//   CNT_W       : instret width (must equal the interface CNT_W)
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit HALT_ON_SYS = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_control_fsm_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM    = 4'd3,
        S_WB     = 4'd4,
        S_TRAP   = 4'd5,
        S_HALT   = 4'd6
    } state_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_OPI   = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    // The wait counter only has to reach MEM_TIMEOUT-1.
    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   instret_q;

    logic       fetch_cycle, ir_write, pc_write, reg_write;
    logic       mem_read, mem_write, is_branch, is_jal, is_jalr;
    logic [1:0] alu_src_a, alu_src_b, wb_sel;
    logic       trap, halted;
    logic       timeout_hit;
    logic       op_legal;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wcnt_q == WCNT_LAST);

    always_comb begin
        op_legal = 1'b0;
        case (bus.opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
            OP_LD, OP_ST, OP_OPI, OP_OP:  op_legal = 1'b1;
            OP_SYS:                       op_legal = (bus.funct3 == 3'd0);
            default:                      op_legal = 1'b0;
        endcase
    end

    // State, wait counter, trap cause and instret registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wcnt_q    <= '0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            cause_q <= cause_d;
            if (pc_write) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        cause_d     = cause_q;
        fetch_cycle = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        wb_sel      = 2'b00;
        trap        = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_FETCH: begin
                fetch_cycle = 1'b1;
                alu_src_a   = 2'b01;   // PC + 4 computed during fetch
                alu_src_b   = 2'b10;
                // A stalled fetch freezes the wait counter rather than
                // clearing it, so stalls neither cause nor mask a timeout.
                if (!bus.stall_req) begin
                    mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        wcnt_d   = '0;
                        state_d  = S_DECODE;
                    end else if (timeout_hit) begin
                        cause_d = CAUSE_BUS;
                        state_d = S_TRAP;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end

            S_DECODE: begin
                if (!op_legal) begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = S_TRAP;
                end else if (bus.opcode == OP_SYS) begin
                    if (HALT_ON_SYS) begin
                        state_d = S_HALT;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (bus.opcode)
                    OP_BR: begin
                        is_branch = 1'b1;
                        pc_write  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_JAL: begin
                        is_jal    = 1'b1;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        state_d   = S_FETCH;
                    end
                    OP_JALR: begin
                        is_jalr   = 1'b1;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        state_d   = S_FETCH;
                    end
                    OP_LUI: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b01;
                        state_d   = S_WB;
                    end
                    OP_AUIPC: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b01;
                        state_d   = S_WB;
                    end
                    OP_OPI: begin
                        alu_src_b = 2'b01;
                        state_d   = S_WB;
                    end
                    OP_OP: begin
                        state_d = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_src_b = 2'b01;   // address = rs1 + imm
                        state_d   = S_MEM;
                    end
                    default: begin
                        // Only reachable if the IR changed after DECODE.
                        cause_d = CAUSE_ILLEGAL;
                        state_d = S_TRAP;
                    end
                endcase
            end

            S_MEM: begin
                if (bus.opcode == OP_ST) begin
                    mem_write = 1'b1;
                    pc_write  = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        wcnt_d  = '0;
                        state_d = S_WB;
                    end else if (timeout_hit) begin
                        cause_d = CAUSE_BUS;
                        state_d = S_TRAP;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                wb_sel    = (bus.opcode == OP_LD) ? 2'b01 : 2'b00;
                state_d   = S_FETCH;
            end

            S_TRAP: begin
                trap   = 1'b1;
                halted = 1'b1;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // While reset is held the core keeps presenting a fetch of PC so the
        // memory can start early; nothing else may leave the sequencer.
        if (!rst_n) begin
            fetch_cycle = 1'b1;
            mem_read    = ~bus.stall_req;
            ir_write    = 1'b0;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
        end
    end

    assign bus.fetch_cycle = fetch_cycle;
    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.reg_write   = reg_write;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.is_branch   = is_branch;
    assign bus.is_jal      = is_jal;
    assign bus.is_jalr     = is_jalr;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.wb_sel      = wb_sel;
    assign bus.state       = state_q;
    assign bus.trap        = trap;
    assign bus.trap_cause  = cause_q;
    assign bus.halted      = halted;
    assign bus.instret     = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
// Drives instruction-level stimulus into mc_control_fsm. Every cycle the
// driver also queues the output vector that cycle must show, worked out from
// the instruction class, the memory wait pattern and the timeout rule. A
// compare process on the falling edge checks the DUT against that queue.
// A narrow instret (CNT_W=4) makes the counter wrap during the run.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 16;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_EXEC   = 4'd2;
    localparam logic [3:0] ST_MEM    = 4'd3;
    localparam logic [3:0] ST_WB     = 4'd4;
    localparam logic [3:0] ST_TRAP   = 4'd5;
    localparam logic [3:0] ST_HALT   = 4'd6;

    typedef struct packed {
        logic [3:0] state;
        logic       fetch_cycle;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] wb_sel;
        logic       trap;
        logic [1:0] trap_cause;
        logic       halted;
    } obs_t;

    localparam int EXP_W = $bits(obs_t) + CNT_W;

    typedef enum int {
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_OPI, C_OP,
        C_SYS_HALT, C_ILLEGAL
    } cls_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    mc_control_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .HALT_ON_SYS (1'b1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    string            tag_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc_cnt  = 0;
    logic [CNT_W-1:0] model_instret = '0;
    logic [1:0]       model_cause   = 2'b00;

    logic [6:0] legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b1100111, 7'b1100011, 7'b0000011,
                                  7'b0100011, 7'b0010011, 7'b0110011};

    function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BR;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b0010011: return C_OPI;
            7'b0110011: return C_OP;
            7'b1110011: return (f3 == 3'd0) ? C_SYS_HALT : C_ILLEGAL;
            default:    return C_ILLEGAL;
        endcase
    endfunction

    function automatic obs_t obs_now();
        obs_t o;
        o.state       = bus.state;
        o.fetch_cycle = bus.fetch_cycle;
        o.ir_write    = bus.ir_write;
        o.pc_write    = bus.pc_write;
        o.reg_write   = bus.reg_write;
        o.mem_read    = bus.mem_read;
        o.mem_write   = bus.mem_write;
        o.is_branch   = bus.is_branch;
        o.is_jal      = bus.is_jal;
        o.is_jalr     = bus.is_jalr;
        o.alu_src_a   = bus.alu_src_a;
        o.alu_src_b   = bus.alu_src_b;
        o.wb_sel      = bus.wb_sel;
        o.trap        = bus.trap;
        o.trap_cause  = bus.trap_cause;
        o.halted      = bus.halted;
        return o;
    endfunction

    // Quiet cycle in a given state: no strobes, cause register as modelled.
    function automatic obs_t o_idle(input logic [3:0] s);
        obs_t o;
        o = '0;
        o.state      = s;
        o.trap_cause = model_cause;
        o.halted     = (s == ST_TRAP) || (s == ST_HALT);
        o.trap       = (s == ST_TRAP);
        return o;
    endfunction

    function automatic obs_t o_fetch(input logic stall, input logic ready);
        obs_t o;
        o = o_idle(ST_FETCH);
        o.fetch_cycle = 1'b1;
        o.alu_src_a   = 2'b01;
        o.alu_src_b   = 2'b10;
        o.mem_read    = ~stall;
        o.ir_write    = ~stall & ready;
        return o;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            logic [EXP_W-1:0] a;
            string            t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {obs_now(), bus.instret};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: actual obs=%h instret=%0d, required obs=%h instret=%0d",
                         t, $time, a[EXP_W-1:CNT_W], a[CNT_W-1:0],
                         e[EXP_W-1:CNT_W], e[CNT_W-1:0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: apply inputs, queue the expected outputs, advance.
    task automatic cyc(input logic stall, input logic ready, input obs_t o, input string tag);
        bus.stall_req = stall;
        bus.mem_ready = ready;
        exp_q.push_back({o, model_instret});
        tag_q.push_back(tag);
        if (o.pc_write) model_instret = model_instret + 1'b1;
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Cycle in which stall_req and mem_ready must not matter.
    task automatic cyc_rand(input obs_t o, input string tag);
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, tag);
    endtask

    task automatic do_reset(input int n);
        rst_n         = 1'b0;
        model_instret = '0;
        model_cause   = 2'b00;
        repeat (n) begin
            logic s;
            obs_t o;
            s = 1'($urandom_range(0, 1));
            o = '0;
            o.fetch_cycle = 1'b1;
            o.mem_read    = ~s;
            cyc(s, 1'b0, o, "reset");
        end
        rst_n = 1'b1;
    endtask

    // Fetch with `waits` not-ready cycles and `stalls` stall cycles mixed in.
    // The timeout counts only non-stalled waits of the current access.
    task automatic fetch_phase(input int waits, input int stalls, output bit trapped);
        int waited;
        waited  = 0;
        trapped = 1'b0;
        forever begin
            if (stalls > 0 && (waited >= waits || $urandom_range(0, 1) == 1)) begin
                logic r;
                r = 1'($urandom_range(0, 1));
                cyc(1'b1, r, o_fetch(1'b1, r), "fetch_stall");
                stalls--;
            end else if (waited < waits) begin
                cyc(1'b0, 1'b0, o_fetch(1'b0, 1'b0), "fetch_wait");
                waited++;
                if (waited == MEM_TIMEOUT) begin
                    model_cause = 2'b10;
                    trapped     = 1'b1;
                    return;
                end
            end else begin
                cyc(1'b0, 1'b1, o_fetch(1'b0, 1'b1), "fetch_done");
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int fwait, input int fstall, input int mwait,
                             output bit terminal);
        cls_t c;
        obs_t o;
        bit   tr;
        int   waited;
        terminal   = 1'b0;
        bus.opcode = op;
        bus.funct3 = f3;
        c = classify(op, f3);

        fetch_phase(fwait, fstall, tr);
        if (tr) begin
            terminal = 1'b1;
            return;
        end

        cyc_rand(o_idle(ST_DECODE), "decode");
        if (c == C_ILLEGAL) begin
            model_cause = 2'b01;
            terminal    = 1'b1;
            return;
        end
        if (c == C_SYS_HALT) begin
            terminal = 1'b1;
            return;
        end

        o = o_idle(ST_EXEC);
        case (c)
            C_BR:    begin o.is_branch = 1'b1; o.pc_write = 1'b1; end
            C_JAL:   begin o.is_jal = 1'b1; o.pc_write = 1'b1; o.reg_write = 1'b1; o.wb_sel = 2'b10; end
            C_JALR:  begin o.is_jalr = 1'b1; o.pc_write = 1'b1; o.reg_write = 1'b1; o.wb_sel = 2'b10; end
            C_LUI:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
            C_AUIPC: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
            C_OPI:   o.alu_src_b = 2'b01;
            C_LD:    o.alu_src_b = 2'b01;
            C_ST:    o.alu_src_b = 2'b01;
            default: ;
        endcase
        cyc_rand(o, "exec");
        if (c == C_BR || c == C_JAL || c == C_JALR) return;

        if (c == C_ST) begin
            o = o_idle(ST_MEM);
            o.mem_write = 1'b1;
            o.pc_write  = 1'b1;
            cyc_rand(o, "mem_store");
            return;
        end

        if (c == C_LD) begin
            waited = 0;
            forever begin
                o = o_idle(ST_MEM);
                o.mem_read = 1'b1;
                if (waited < mwait) begin
                    cyc(1'($urandom_range(0, 1)), 1'b0, o, "mem_wait");
                    waited++;
                    if (waited == MEM_TIMEOUT) begin
                        model_cause = 2'b10;
                        terminal    = 1'b1;
                        return;
                    end
                end else begin
                    cyc(1'($urandom_range(0, 1)), 1'b1, o, "mem_done");
                    break;
                end
            end
        end

        o = o_idle(ST_WB);
        o.reg_write = 1'b1;
        o.pc_write  = 1'b1;
        o.wb_sel    = (c == C_LD) ? 2'b01 : 2'b00;
        cyc_rand(o, "wb");
    endtask

    // TRAP if a cause was recorded, HALT otherwise; inputs must be ignored.
    task automatic terminal_phase(input int n);
        repeat (n) cyc_rand(o_idle((model_cause != 2'b00) ? ST_TRAP : ST_HALT), "terminal");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit   term;
        int   c0;
        bus.opcode    = 7'b0010011;
        bus.funct3    = 3'd0;
        bus.stall_req = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        do_reset(3);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_instret", 32'(bus.instret), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);

        // ADDI x1,x0,5 with no memory wait: 4 cycles.
        c0 = cyc_cnt;
        run_instr(7'b0010011, 3'd0, 0, 0, 0, term);
        check("addi_cycles", 32'(cyc_cnt - c0), 32'd4);
        check("addi_instret", 32'(bus.instret), 32'd1);
        check("addi_state", 32'(bus.state), 32'd0);

        // LW with 3 wait cycles in MEM: 8 cycles.
        c0 = cyc_cnt;
        run_instr(7'b0000011, 3'd2, 0, 0, 3, term);
        check("lw_cycles", 32'(cyc_cnt - c0), 32'd8);
        check("lw_instret", 32'(bus.instret), 32'd2);

        // BEQ: 3 cycles.
        c0 = cyc_cnt;
        run_instr(7'b1100011, 3'd0, 0, 0, 0, term);
        check("beq_cycles", 32'(cyc_cnt - c0), 32'd3);
        check("beq_instret", 32'(bus.instret), 32'd3);

        // SW: 4 cycles.
        c0 = cyc_cnt;
        run_instr(7'b0100011, 3'd2, 0, 0, 0, term);
        check("sw_cycles", 32'(cyc_cnt - c0), 32'd4);

        // Illegal opcode, then 20 quiet cycles.
        run_instr(7'b1111111, 3'd0, 0, 0, 0, term);
        check("illegal_terminal", 32'(term), 32'd1);
        terminal_phase(20);
        check("illegal_state", 32'(bus.state), 32'd5);
        check("illegal_trap", 32'(bus.trap), 32'd1);
        check("illegal_cause", 32'(bus.trap_cause), 32'd1);
        check("illegal_halted", 32'(bus.halted), 32'd1);
        check("illegal_instret", 32'(bus.instret), 32'd4);
        do_reset(2);

        // Fetch never acknowledged: trap after 16 cycles.
        c0 = cyc_cnt;
        run_instr(7'b0010011, 3'd0, 40, 0, 0, term);
        check("fto_cycles", 32'(cyc_cnt - c0), 32'd16);
        terminal_phase(3);
        check("fto_state", 32'(bus.state), 32'd5);
        check("fto_cause", 32'(bus.trap_cause), 32'd2);
        do_reset(2);

        // Stalled fetch never times out.
        repeat (40) cyc(1'b1, 1'b0, o_fetch(1'b1, 1'b0), "stall_hold");
        check("stall_state", 32'(bus.state), 32'd0);
        check("stall_trap", 32'(bus.trap), 32'd0);
        run_instr(7'b0110011, 3'd0, 15, 0, 0, term);
        check("stall_then_op_instret", 32'(bus.instret), 32'd1);

        // ECALL halts without retiring; reset mid-halt clears everything.
        run_instr(7'b1110011, 3'd0, 0, 0, 0, term);
        terminal_phase(4);
        check("ecall_state", 32'(bus.state), 32'd6);
        check("ecall_halted", 32'(bus.halted), 32'd1);
        check("ecall_trap", 32'(bus.trap), 32'd0);
        check("ecall_instret", 32'(bus.instret), 32'd1);
        do_reset(1);
        check("halt_rst_state", 32'(bus.state), 32'd0);
        check("halt_rst_halted", 32'(bus.halted), 32'd0);
        check("halt_rst_instret", 32'(bus.instret), 32'd0);

        // SYSTEM with funct3 != 0 is illegal.
        run_instr(7'b1110011, 3'd1, 0, 0, 0, term);
        terminal_phase(2);
        check("csr_cause", 32'(bus.trap_cause), 32'd1);
        do_reset(2);

        // Reset in the middle of a load's MEM wait.
        run_instr(7'b0010011, 3'd0, 0, 0, 0, term);
        bus.opcode = 7'b0000011;
        fetch_phase(1, 1, term);
        cyc_rand(o_idle(ST_DECODE), "decode");
        begin
            obs_t o;
            o = o_idle(ST_EXEC);
            o.alu_src_b = 2'b01;
            cyc_rand(o, "exec");
            o = o_idle(ST_MEM);
            o.mem_read = 1'b1;
            repeat (3) cyc(1'b0, 1'b0, o, "mem_wait");
        end
        do_reset(1);
        check("midrst_state", 32'(bus.state), 32'd0);
        check("midrst_instret", 32'(bus.instret), 32'd0);

        // Random programs.
        for (int ep = 0; ep < 25; ep++) begin
            int n_instr;
            do_reset($urandom_range(1, 3));
            n_instr = $urandom_range(3, 25);
            for (int k = 0; k < n_instr; k++) begin
                logic [6:0] op;
                logic [2:0] f3;
                int         fw, fs, mw, pick;
                pick = $urandom_range(0, 39);
                f3   = 3'($urandom_range(0, 7));
                if (pick == 0) begin
                    op = 7'b1110011;
                    f3 = 3'd0;
                end else if (pick == 1) begin
                    do begin
                        op = 7'($urandom_range(0, 127));
                        f3 = 3'($urandom_range(0, 7));
                    end while (classify(op, f3) != C_ILLEGAL);
                end else begin
                    op = legal_ops[$urandom_range(0, 8)];
                end
                fw = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 18) : $urandom_range(0, 3);
                fs = $urandom_range(0, 3);
                mw = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 18) : $urandom_range(0, 3);
                run_instr(op, f3, fw, fs, mw, term);
                if (term) begin
                    terminal_phase(5);
                    break;
                end
            end
        end

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
